// File: rtl/adder_nbit_serial.sv
`default_nettype none
// ============================================================================
// Module   : adder_nbit_serial
// Brief    : Bit-serial WIDTH-bit adder/subtractor, LSB first, one full-adder
//            cell selectable between XOR logic and maj3+NOT logic.
// Revision : 1.0 - initial release
// ============================================================================
module adder_nbit_serial #(
    parameter int WIDTH     = 8,
    parameter int IMPL_TYPE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int              CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic               w_a, w_b, w_c, w_s, w_co;
    logic [WIDTH-1:0]   w_sr_next;

    assign w_a = opa_q[0];
    assign w_b = opb_q[0];
    assign w_c = c_q;

    generate
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $fatal(1, "adder_nbit_serial: WIDTH %0d outside 1..64", WIDTH);
        end

        if (IMPL_TYPE == 0) begin : g_fa_xor
            assign w_s  = w_a ^ w_b ^ w_c;
            assign w_co = (w_a & w_b) | (w_c & (w_a ^ w_b));
        end else if (IMPL_TYPE == 1) begin : g_fa_maj
            // Majority-only cell so PIM arrays can model row-wise MAJ logic.
            assign w_co = maj3(w_a, w_b, w_c);
            assign w_s  = maj3(~w_co, w_c, maj3(w_a, w_b, ~w_c));
        end else begin : g_bad_impl
            $fatal(1, "adder_nbit_serial: unsupported IMPL_TYPE %0d", IMPL_TYPE);
            assign w_s  = 1'b0;
            assign w_co = 1'b0;
        end

        if (WIDTH == 1) begin : g_sr_w1
            assign w_sr_next = w_s;
        end else begin : g_sr_wn
            assign w_sr_next = {w_s, sr_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    opa_d   = A;
                    opb_d   = Sub ? ~B : B;
                    c_d     = Sub;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                opa_d = opa_q >> 1;
                opb_d = opb_q >> 1;
                c_d   = w_co;
                cnt_d = cnt_q + CNT_W'(1);
                sr_d  = w_sr_next;
                // Final bit: publish the result including this cycle's sum bit.
                if (cnt_q == C_LAST) begin
                    sum_d   = w_sr_next;
                    cout_d  = w_co;
                    ovf_d   = w_c ^ w_co;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sr_q    <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_nbit_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_nbit_serial
// Brief    : Self-checking bench for adder_nbit_serial, both cell types,
//            WIDTH=8 directed/random and WIDTH=4 exhaustive.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_nbit_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       iv8, or8, sub8;
    logic [7:0] a8, b8;
    logic       ir8 [2];
    logic       ov8 [2];
    logic       co8 [2];
    logic       vf8 [2];
    logic [7:0] s8  [2];

    logic       iv4, or4, sub4;
    logic [3:0] a4, b4;
    logic       ir4 [2];
    logic       ov4 [2];
    logic       co4 [2];
    logic       vf4 [2];
    logic [3:0] s4  [2];

    int n_vec = 0;
    int n_bad = 0;

    for (genvar k = 0; k < 2; k++) begin : g_dut8
        adder_nbit_serial #(.WIDTH(8), .IMPL_TYPE(k)) u_dut (
            .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8[k]),
            .A(a8), .B(b8), .Sub(sub8), .out_valid(ov8[k]), .out_ready(or8),
            .Sum(s8[k]), .Cout(co8[k]), .Ovf(vf8[k])
        );
    end

    for (genvar k = 0; k < 2; k++) begin : g_dut4
        adder_nbit_serial #(.WIDTH(4), .IMPL_TYPE(k)) u_dut (
            .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4[k]),
            .A(a4), .B(b4), .Sub(sub4), .out_valid(ov4[k]), .out_ready(or4),
            .Sum(s4[k]), .Cout(co4[k]), .Ovf(vf4[k])
        );
    end

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic void model(input int w, input int a, input int b, input bit sub,
                                  output int s, output bit co, output bit ov);
        int m, sa, sb, r;
        m  = 1 << w;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        r  = sub ? sa - sb : sa + sb;
        ov = (r < -(m / 2)) || (r > m / 2 - 1);
        co = sub ? (a >= b) : (a + b >= m);
        s  = sub ? (a - b + m) % m : (a + b) % m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready8();
        int t = 0;
        while (!ir8[0] && t < 50) begin
            tick();
            t++;
        end
    endtask

    task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input bit sub,
                             input bit toggle, output int lat);
        wait_ready8();
        a8 = a; b8 = b; sub8 = sub; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        lat = 0;
        while (!ov8[0] && lat < 40) begin
            if (toggle) begin
                a8 = 8'($urandom); b8 = 8'($urandom);
                sub8 = 1'($urandom); iv8 = 1'($urandom); or8 = 1'($urandom);
            end
            tick();
            lat++;
        end
        iv8 = 1'b0;
        or8 = 1'b0;
    endtask

    task automatic handshake8();
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (ir8[k] !== 1'b0 || ov8[k] !== 1'b0 || s8[k] !== 8'h00 || co8[k] !== 1'b0 || vf8[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset8[%0d] got ir=%b ov=%b sum=%h co=%b ovf=%b want 0 0 00 0 0",
                         k, ir8[k], ov8[k], s8[k], co8[k], vf8[k]);
            end
            n_vec++;
            if (ir4[k] !== 1'b0 || ov4[k] !== 1'b0 || s4[k] !== 4'h0 || co4[k] !== 1'b0 || vf4[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset4[%0d] got ir=%b ov=%b sum=%h co=%b ovf=%b want 0 0 0 0 0",
                         k, ir4[k], ov4[k], s4[k], co4[k], vf4[k]);
            end
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (ir8[k] !== 1'b1 || ir4[k] !== 1'b1) begin
                n_bad++;
                $display("FAIL ready_after_reset[%0d] got ir8=%b ir4=%b want 1 1", k, ir8[k], ir4[k]);
            end
        end
    endtask

    task automatic test_directed();
        logic [7:0] ta [4] = '{8'hC8, 8'h7F, 8'h80, 8'h05};
        logic [7:0] tb [4] = '{8'h64, 8'h01, 8'h01, 8'h07};
        bit         tsb[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] ts [4] = '{8'h2C, 8'h80, 8'h7F, 8'hFE};
        bit         tc [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        bit         tv [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 4; i++) begin
            start_op8(ta[i], tb[i], tsb[i], 1'b0, lat);
            n_vec++;
            if (lat !== 8) begin
                n_bad++;
                $display("FAIL latency8 op%0d got %0d want 8", i, lat);
            end
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (s8[k] !== ts[i] || co8[k] !== tc[i] || vf8[k] !== tv[i]) begin
                    n_bad++;
                    $display("FAIL directed[%0d] op%0d got sum=%h co=%b ovf=%b want %h %b %b",
                             k, i, s8[k], co8[k], vf8[k], ts[i], tc[i], tv[i]);
                end
            end
            handshake8();
        end
    endtask

    task automatic test_toggle();
        int lat;
        start_op8(8'h05, 8'h07, 1'b1, 1'b1, lat);
        n_vec++;
        if (lat !== 8) begin
            n_bad++;
            $display("FAIL latency_toggle got %0d want 8", lat);
        end
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (s8[k] !== 8'hFE || co8[k] !== 1'b0 || vf8[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL toggle[%0d] got sum=%h co=%b ovf=%b want fe 0 0", k, s8[k], co8[k], vf8[k]);
            end
        end
        handshake8();
    endtask

    task automatic test_backpressure();
        int lat, es;
        bit ec, ev;
        logic [7:0] a, b;
        a = 8'($urandom); b = 8'($urandom);
        model(8, int'(a), int'(b), 1'b0, es, ec, ev);
        start_op8(a, b, 1'b0, 1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); iv8 = 1'b1; or8 = 1'b0;
            tick();
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (ov8[k] !== 1'b1 || ir8[k] !== 1'b0 || s8[k] !== 8'(es) || co8[k] !== ec || vf8[k] !== ev) begin
                    n_bad++;
                    $display("FAIL backpressure[%0d] cyc%0d got ov=%b ir=%b sum=%h co=%b ovf=%b want 1 0 %h %b %b",
                             k, i, ov8[k], ir8[k], s8[k], co8[k], vf8[k], 8'(es), ec, ev);
                end
            end
        end
        iv8 = 1'b0;
        handshake8();
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (ov8[k] !== 1'b0 || ir8[k] !== 1'b1) begin
                n_bad++;
                $display("FAIL release[%0d] got ov=%b ir=%b want 0 1", k, ov8[k], ir8[k]);
            end
        end
        a = 8'($urandom); b = 8'($urandom);
        model(8, int'(a), int'(b), 1'b1, es, ec, ev);
        start_op8(a, b, 1'b1, 1'b0, lat);
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (s8[k] !== 8'(es) || co8[k] !== ec || vf8[k] !== ev) begin
                n_bad++;
                $display("FAIL after_release[%0d] got sum=%h co=%b ovf=%b want %h %b %b",
                         k, s8[k], co8[k], vf8[k], 8'(es), ec, ev);
            end
        end
        handshake8();
    endtask

    task automatic test_back_to_back();
        int cyc = 0, last = -1, t, es;
        bit ec, ev;
        or8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); iv8 = 1'b1;
            t = 0;
            while (!ir8[0] && t < 30) begin
                tick(); cyc++; t++;
            end
            if (last >= 0) begin
                n_vec++;
                if (cyc - last !== 10) begin
                    n_bad++;
                    $display("FAIL throughput op%0d got %0d cycles want 10", i, cyc - last);
                end
            end
            last = cyc;
            model(8, int'(a8), int'(b8), sub8, es, ec, ev);
            tick(); cyc++;
            a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
            t = 0;
            while (!ov8[0] && t < 30) begin
                tick(); cyc++; t++;
            end
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (ov8[k] !== 1'b1 || s8[k] !== 8'(es) || co8[k] !== ec || vf8[k] !== ev) begin
                    n_bad++;
                    $display("FAIL back_to_back[%0d] op%0d got ov=%b sum=%h co=%b ovf=%b want 1 %h %b %b",
                             k, i, ov8[k], s8[k], co8[k], vf8[k], 8'(es), ec, ev);
                end
            end
        end
        tick();
        or8 = 1'b0;
        iv8 = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int lat;
        start_op8(8'hC8, 8'h64, 1'b0, 1'b0, lat);
        handshake8();
        wait_ready8();
        a8 = 8'h33; b8 = 8'h11; sub8 = 1'b0; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (ov8[k] !== 1'b0 || s8[k] !== 8'h00 || co8[k] !== 1'b0 || ir8[k] !== 1'b1) begin
                n_bad++;
                $display("FAIL rst_mid_run[%0d] got ov=%b sum=%h co=%b ir=%b want 0 00 0 1",
                         k, ov8[k], s8[k], co8[k], ir8[k]);
            end
        end
        start_op8(8'h10, 8'h20, 1'b0, 1'b0, lat);
        n_vec++;
        if (lat !== 8) begin
            n_bad++;
            $display("FAIL latency_after_rst got %0d want 8", lat);
        end
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (s8[k] !== 8'h30 || co8[k] !== 1'b0 || vf8[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL op_after_rst[%0d] got sum=%h co=%b ovf=%b want 30 0 0", k, s8[k], co8[k], vf8[k]);
            end
        end
        handshake8();
        start_op8(8'hFF, 8'hFF, 1'b0, 1'b0, lat);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (ov8[k] !== 1'b0 || s8[k] !== 8'h00 || co8[k] !== 1'b0 || ir8[k] !== 1'b1) begin
                n_bad++;
                $display("FAIL rst_in_done[%0d] got ov=%b sum=%h co=%b ir=%b want 0 00 0 1",
                         k, ov8[k], s8[k], co8[k], ir8[k]);
            end
        end
    endtask

    task automatic test_random8();
        int lat, es;
        bit ec, ev, sub;
        logic [7:0] a, b;
        for (int i = 0; i < 30; i++) begin
            a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
            model(8, int'(a), int'(b), sub, es, ec, ev);
            start_op8(a, b, sub, 1'b0, lat);
            repeat ($urandom_range(0, 3)) tick();
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (ov8[k] !== 1'b1 || s8[k] !== 8'(es) || co8[k] !== ec || vf8[k] !== ev) begin
                    n_bad++;
                    $display("FAIL random8[%0d] a=%h b=%h sub=%b got ov=%b sum=%h co=%b ovf=%b want 1 %h %b %b",
                             k, a, b, sub, ov8[k], s8[k], co8[k], vf8[k], 8'(es), ec, ev);
                end
            end
            handshake8();
        end
    endtask

    task automatic test_exhaustive4();
        int t, es;
        bit ec, ev;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int s = 0; s < 2; s++) begin
                    model(4, a, b, 1'(s), es, ec, ev);
                    t = 0;
                    while (!ir4[0] && t < 50) begin
                        tick(); t++;
                    end
                    a4 = 4'(a); b4 = 4'(b); sub4 = 1'(s); iv4 = 1'b1;
                    tick();
                    iv4 = 1'b0;
                    t = 0;
                    while (!ov4[0] && t < 50) begin
                        or4 = 1'($urandom);
                        tick(); t++;
                    end
                    or4 = 1'b0;
                    for (int k = 0; k < 2; k++) begin
                        n_vec++;
                        if (t !== 4 || ov4[k] !== 1'b1 || s4[k] !== 4'(es) || co4[k] !== ec || vf4[k] !== ev) begin
                            n_bad++;
                            $display("FAIL exh4[%0d] a=%h b=%h sub=%0d got lat=%0d ov=%b sum=%h co=%b ovf=%b want 4 1 %h %b %b",
                                     k, a, b, s, t, ov4[k], s4[k], co4[k], vf4[k], 4'(es), ec, ev);
                        end
                    end
                    t = 0;
                    do begin
                        or4 = (t >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
                        tick(); t++;
                    end while (ov4[0] && t < 30);
                    or4 = 1'b0;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        iv8 = 1'b0; or8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
        iv4 = 1'b0; or4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
        test_reset();
        test_directed();
        test_toggle();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_random8();
        test_exhaustive4();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete, vectors=%0d miscompares=%0d", n_vec, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
